// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display scan controller
//
// Purpose: scan state encoding, blank segment pattern and largest legal BCD
// digit, shared by the scan controller and its testbench.
// Ports: none (package).

package disp_pkg;

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - BCD/hex to seven-segment decoder, active-high
//
// Purpose: combinational nibble decoder, segment order {a,b,c,d,e,f,g}
// with segment a in bit 6.
// Ports:
//   i_bcd  in  4  nibble to decode
//   o_seg  out 7  segment pattern, active-high

module seven_segment (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'h0:    o_seg = 7'b1111110;
      4'h1:    o_seg = 7'b0110000;
      4'h2:    o_seg = 7'b1101101;
      4'h3:    o_seg = 7'b1111001;
      4'h4:    o_seg = 7'b0110011;
      4'h5:    o_seg = 7'b1011011;
      4'h6:    o_seg = 7'b1011111;
      4'h7:    o_seg = 7'b1110000;
      4'h8:    o_seg = 7'b1111111;
      4'h9:    o_seg = 7'b1111011;
      4'hA:    o_seg = 7'b1110111;
      4'hB:    o_seg = 7'b0011111;
      4'hC:    o_seg = 7'b1001110;
      4'hD:    o_seg = 7'b0111101;
      4'hE:    o_seg = 7'b1001111;
      default: o_seg = 7'b1000111;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed seven-segment scan for the RTC display
//
// Purpose: snapshots the packed BCD time once per frame and scans the digits
// with a dwell window (anode on) followed by an all-off blanking window.
// Optional feature macro: DISP_BLINK_EN (per-digit blinking).
// Ports:
//   clk          in  1             system clock
//   rst          in  1             synchronous, active-high reset
//   digits_bcd   in  4*NUM_DIGITS  packed BCD, digit 0 in [3:0]
//   blink_mask   in  NUM_DIGITS    per-digit blink request (DISP_BLINK_EN only)
//   an           out NUM_DIGITS    one-hot digit enable, active-high
//   seg          out 7             segment pattern, active-high
//   frame_start  out 1             pulse in the first cycle of digit 0

module display_scan_controller
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_start
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  disp_state_e             r_state;
  disp_state_e             w_state_n;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_n;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_frame_start;
  logic                    w_scan_done;
  logic                    w_blank_done;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec;
  logic [6:0]              w_seg_n;
  logic                    w_blink_off;

  // Outputs are registered from next-state values, so every decision below
  // is made on the digit that will be shown after this edge.
  always_comb begin
    w_scan_done  = (r_state == SCAN)  && (r_cnt == DWELL_LAST);
    w_blank_done = (r_state == BLANK) && (r_cnt == BLANK_LAST);
    w_wrap       = w_blank_done && (r_idx == IDX_LAST);
    w_idx_n      = r_idx;
    if (w_blank_done) begin
      w_idx_n = w_wrap ? '0 : r_idx + IW'(1);
    end
    w_state_n = r_state;
    if (w_scan_done) begin
      w_state_n = BLANK;
    end else if (w_blank_done) begin
      w_state_n = SCAN;
    end
    // On wrap the snapshot is loaded on this same edge, so digit 0 of the
    // new frame has to be decoded straight from the input word.
    w_nibble = w_wrap ? digits_bcd[3:0] : r_snap[{w_idx_n, 2'b00} +: 4];
  end

  seven_segment u_dec (
    .i_bcd (w_nibble),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg_n = w_dec;
    if (w_nibble > BCD_MAX) begin
      w_seg_n = SEG_BLANK;
    end
    if ((LZB != 0) && (w_idx_n == IDX_LAST) && (w_nibble == 4'd0)) begin
      w_seg_n = SEG_BLANK;
    end
    if (w_blink_off || (w_state_n != SCAN)) begin
      w_seg_n = SEG_BLANK;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int                FW       = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0]     FCNT_TOP = FW'(BLINK_FRAMES);

  logic [NUM_DIGITS-1:0] r_mask;
  logic                  r_phase;
  logic                  w_phase_n;
  logic [FW-1:0]         r_fcnt;

  // r_fcnt holds how many frames have started in the current phase; the
  // phase flips as the frame after the BLINK_FRAMES-th one begins.
  always_comb begin
    w_phase_n = r_phase;
    if (w_wrap && (r_fcnt == FCNT_TOP)) begin
      w_phase_n = ~r_phase;
    end
    w_blink_off = (w_wrap ? w_phase_n : r_phase) &&
                  (w_wrap ? blink_mask[0] : r_mask[w_idx_n]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask  <= '0;
      r_phase <= 1'b0;
      r_fcnt  <= '0;
    end else if (w_wrap) begin
      r_mask  <= blink_mask;
      r_phase <= w_phase_n;
      r_fcnt  <= (r_fcnt == FCNT_TOP) ? FW'(1) : r_fcnt + FW'(1);
    end
  end
`else
  localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_blink_off    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BLANK;
      r_cnt         <= '0;
      r_idx         <= IDX_LAST;
      r_snap        <= '0;
      r_an          <= '0;
      r_seg         <= SEG_BLANK;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= (w_scan_done || w_blank_done) ? '0 : r_cnt + CW'(1);
      r_idx         <= w_idx_n;
      if (w_wrap) begin
        r_snap <= digits_bcd;
      end
      r_an          <= (w_state_n == SCAN) ? (AN_ONE << w_idx_n) : '0;
      r_seg         <= w_seg_n;
      r_frame_start <= w_wrap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller

module tb_display_scan_controller;

  localparam int ND = 6;
  localparam int DW = 4;
  localparam int BL = 2;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] SB = 7'b0000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   digits_bcd;
  logic [ND-1:0] blink_mask;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          frame_start;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  display_scan_controller #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .LZB          (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_bcd  (digits_bcd),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Blank cycles left after reset release before digit 0 (the first blank
  // cycle is the one where reset is released).
  task automatic post_reset_blank();
    for (int c = 0; c < BL - 1; c++) begin
      tick();
      check_eq("post_rst_an", 32'(an), 32'd0);
      check_eq("post_rst_seg", 32'(seg), 32'd0);
    end
  endtask

  // exp holds {d5,d4,d3,d2,d1,d0} segment patterns. Optionally changes the
  // input word at the start of chg_digit, or asserts rst on the second dwell
  // clock of stop_digit and returns.
  task automatic scan_frame(input logic [41:0] exp, input int chg_digit,
                            input logic [23:0] chg_val, input int stop_digit);
    logic [ND-1:0] one;
    one = ND'(1);
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < DW; c++) begin
        tick();
        check_eq($sformatf("an_d%0d", d), 32'(an), 32'(one << d));
        check_eq($sformatf("seg_d%0d", d), 32'(seg), 32'(exp[d*7 +: 7]));
        check_eq($sformatf("fs_d%0d", d), 32'(frame_start), 32'((d == 0) && (c == 0)));
        if (d == chg_digit && c == 0) digits_bcd = chg_val;
        if (d == stop_digit && c == 1) begin
          rst = 1'b1;
          return;
        end
      end
      for (int c = 0; c < BL; c++) begin
        tick();
        check_eq("blank_an", 32'(an), 32'd0);
        check_eq("blank_seg", 32'(seg), 32'd0);
        check_eq("blank_fs", 32'(frame_start), 32'd0);
      end
    end
  endtask

  initial begin
    logic [41:0] exp;
    bit          blink_build;
`ifdef DISP_BLINK_EN
    blink_build = 1'b1;
`else
    blink_build = 1'b0;
`endif
    rst        = 1'b1;
    digits_bcd = 24'h123456;
    blink_mask = '0;
    tick();
    tick();
    check_eq("rst_an", 32'(an), 32'd0);
    check_eq("rst_seg", 32'(seg), 32'd0);
    check_eq("rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    post_reset_blank();

    // 123456; switch to all zeros while digit 3 is shown (no tearing)
    scan_frame({S1, S2, S3, S4, S5, S6}, 3, 24'h000000, -1);
    // zeros with MSD blanked; load 012345 mid-frame
    scan_frame({SB, S0, S0, S0, S0, S0}, 1, 24'h012345, -1);
    // leading-zero MSD blank, digit 4 shows 1; load invalid nibble on digit 2
    scan_frame({SB, S1, S2, S3, S4, S5}, 2, 24'h123C56, -1);
    scan_frame({S1, S2, S3, SB, S5, S6}, -1, 24'h0, -1);
    // reset on the 2nd dwell clock of digit 3
    scan_frame({S1, S2, S3, SB, S5, S6}, -1, 24'h0, 3);
    tick();
    check_eq("midrst_an", 32'(an), 32'd0);
    check_eq("midrst_seg", 32'(seg), 32'd0);
    check_eq("midrst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    post_reset_blank();
    scan_frame({S1, S2, S3, SB, S5, S6}, -1, 24'h0, -1);

    // blink: frames 2-3 after reset blank digits 0-1 when the feature is built
    rst        = 1'b1;
    digits_bcd = 24'h123456;
    blink_mask = 6'b000011;
    tick();
    rst = 1'b0;
    post_reset_blank();
    for (int f = 0; f < 6; f++) begin
      if (blink_build && ((f / 2) % 2 == 1)) exp = {S1, S2, S3, S4, SB, SB};
      else                                    exp = {S1, S2, S3, S4, S5, S6};
      scan_frame(exp, -1, 24'h0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
